// File: rtl/axis_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : axis_accumulator
// Description : Signed AXI-Stream frame accumulator. Sums NUM_BEATS signed
//               DATA_W-bit input beats and emits the total as one output
//               beat; accu_finished pulses when that beat is accepted.
//               Build option: define ACCU_SAT_EN for saturating adds
//               (wrapping two's-complement adds otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module axis_accumulator #(
    parameter int DATA_W    = 64,
    parameter int NUM_BEATS = 11,
    parameter int CNT_W     = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              accu_en,
    output logic              accu_finished,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                s_ready_q, s_ready_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                finished_q, finished_d;

    logic [DATA_W-1:0]   w_sum_raw;
    logic [DATA_W-1:0]   w_sum;
    logic                w_beat;

    assign w_sum_raw = acc_q + s_axis_tdata;
    assign w_beat    = s_axis_tvalid & s_ready_q;

`ifdef ACCU_SAT_EN
    logic w_ovf_pos;
    logic w_ovf_neg;

    // Overflow only occurs when both operands share a sign the result lacks.
    assign w_ovf_pos = ~acc_q[DATA_W-1] & ~s_axis_tdata[DATA_W-1] &  w_sum_raw[DATA_W-1];
    assign w_ovf_neg =  acc_q[DATA_W-1] &  s_axis_tdata[DATA_W-1] & ~w_sum_raw[DATA_W-1];

    // Clamp to the most positive / most negative representable value.
    always_comb begin
        w_sum = w_sum_raw;
        if (w_ovf_pos) begin
            w_sum = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_ovf_neg) begin
            w_sum = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end
`else
    assign w_sum = w_sum_raw;
`endif

    // Next-state and registered-output logic for the frame FSM.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        s_ready_d  = s_ready_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        finished_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                acc_d     = '0;
                cnt_d     = '0;
                s_ready_d = 1'b0;
                if (accu_en) begin
                    state_d   = ST_ACCUM;
                    s_ready_d = 1'b1;
                end
            end

            ST_ACCUM: begin
                if (!accu_en) begin
                    // Abort: partial sum discarded, no result produced.
                    state_d   = ST_IDLE;
                    acc_d     = '0;
                    cnt_d     = '0;
                    s_ready_d = 1'b0;
                end else if (w_beat) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d   = ST_OUTPUT;
                        m_data_d  = w_sum;
                        m_valid_d = 1'b1;
                        s_ready_d = 1'b0;
                        acc_d     = w_sum;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end else begin
                        acc_d = w_sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_OUTPUT: begin
                // accu_en is deliberately ignored here: the result is always delivered.
                if (m_valid_q && m_axis_tready) begin
                    state_d    = ST_IDLE;
                    m_valid_d  = 1'b0;
                    finished_d = 1'b1;
                    acc_d      = '0;
                    cnt_d      = '0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                acc_d     = '0;
                cnt_d     = '0;
                s_ready_d = 1'b0;
                m_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            finished_q <= finished_d;
        end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign accu_finished = finished_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_accumulator
// Description : Directed self-checking bench for axis_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_accumulator;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        accu_en = 1'b0;
    logic        accu_finished;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [63:0] m_axis_tdata;

    int total = 0;
    int bad   = 0;

    axis_accumulator #(
        .DATA_W    (64),
        .NUM_BEATS (11),
        .CNT_W     (16)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .accu_en       (accu_en),
        .accu_finished (accu_finished),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until the accumulator is ready, then transfer one beat.
    task automatic send_beat(input logic [63:0] val);
        int k = 0;
        while (!s_axis_tready && k < 50) begin
            tick();
            k++;
        end
        check("s_tready_timeout", {63'd0, s_axis_tready}, 64'd1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = val;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    // Back-to-back burst of n beats of the same value.
    task automatic send_burst(input logic [63:0] val, input int n);
        int k = 0;
        while (!s_axis_tready && k < 50) begin
            tick();
            k++;
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = val;
        for (int i = 0; i < n; i++) begin
            check("burst_tready", {63'd0, s_axis_tready}, 64'd1);
            tick();
        end
        s_axis_tvalid = 1'b0;
    endtask

    // Bounded wait for the result, check it, then complete the handshake.
    task automatic get_result(input string tag, input logic [63:0] exp);
        int k = 0;
        while (!m_axis_tvalid && k < 50) begin
            tick();
            k++;
        end
        check({tag, "_valid"}, {63'd0, m_axis_tvalid}, 64'd1);
        check({tag, "_data"}, m_axis_tdata, exp);
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        check({tag, "_fin"}, {63'd0, accu_finished}, 64'd1);
        check({tag, "_vdrop"}, {63'd0, m_axis_tvalid}, 64'd0);
        tick();
        check({tag, "_fin_off"}, {63'd0, accu_finished}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with enable low.
        #1 sys_rst_n = 1'b0;
        #2;
        check("rst_tready", {63'd0, s_axis_tready}, 64'd0);
        check("rst_mvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("rst_mdata",  m_axis_tdata, 64'd0);
        check("rst_fin",    {63'd0, accu_finished}, 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Enable low: offered beats must not be accepted.
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'd999;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("gate_tready", {63'd0, s_axis_tready}, 64'd0);
        end
        s_axis_tvalid = 1'b0;
        check("gate_mvalid", {63'd0, m_axis_tvalid}, 64'd0);

        // Basic frame: 10,0,-10,...,-90 with a gap between beats.
        accu_en = 1'b1;
        tick();
        check("en_tready_rise", {63'd0, s_axis_tready}, 64'd1);
        for (int i = 0; i < 11; i++) begin
            send_beat(64'(10 - 10 * i));
            if (i < 10) tick();
        end
        check("basic_mvalid", {63'd0, m_axis_tvalid}, 64'd1);
        check("basic_tready_low", {63'd0, s_axis_tready}, 64'd0);
        tick();
        check("basic_hold_valid", {63'd0, m_axis_tvalid}, 64'd1);
        get_result("basic", 64'hFFFF_FFFF_FFFF_FE48);
        check("basic_next_tready", {63'd0, s_axis_tready}, 64'd1);

        // Back-to-back beats of 5, then 8 cycles of output backpressure.
        send_burst(64'd5, 11);
        check("b2b_mvalid", {63'd0, m_axis_tvalid}, 64'd1);
        check("b2b_data", m_axis_tdata, 64'd55);
        check("b2b_tready_low", {63'd0, s_axis_tready}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("bp_valid", {63'd0, m_axis_tvalid}, 64'd1);
            check("bp_data", m_axis_tdata, 64'd55);
            check("bp_tready", {63'd0, s_axis_tready}, 64'd0);
            check("bp_fin", {63'd0, accu_finished}, 64'd0);
        end
        get_result("b2b", 64'd55);

        // Abort after 4 beats, then a fresh frame of 1s.
        send_burst(64'd100, 4);
        accu_en = 1'b0;
        tick();
        check("abort_tready", {63'd0, s_axis_tready}, 64'd0);
        tick();
        check("abort_mvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("abort_fin", {63'd0, accu_finished}, 64'd0);
        accu_en = 1'b1;
        send_burst(64'd1, 11);
        get_result("after_abort", 64'd11);

        // Reset mid-frame after 6 beats.
        send_burst(64'd7, 6);
        sys_rst_n = 1'b0;
        #2;
        check("midrst_tready", {63'd0, s_axis_tready}, 64'd0);
        check("midrst_mvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("midrst_mdata", m_axis_tdata, 64'd0);
        check("midrst_fin", {63'd0, accu_finished}, 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        send_burst(64'd3, 11);
        get_result("after_rst", 64'd33);

        // Overflow of maximum positive values.
        send_burst(64'h7FFF_FFFF_FFFF_FFFF, 11);
`ifdef ACCU_SAT_EN
        get_result("overflow", 64'h7FFF_FFFF_FFFF_FFFF);
`else
        get_result("overflow", 64'h7FFF_FFFF_FFFF_FFF5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_accumulator.md
Name: axis_accumulator

Overview:
Signed AXI-Stream accumulator. Sums a fixed-length frame of NUM_BEATS signed 64-bit input beats. Emits the sum as a single beat on the master AXI-Stream port and pulses accu_finished when that beat is accepted. Sits between a DMA MM2S stream (input) and a DMA S2MM stream (output).

Parameters:
DATA_W, 64, width of s_axis_tdata, m_axis_tdata and the internal accumulator (two's complement).
NUM_BEATS, 11, number of input beats per frame (≥1).
CNT_W, 16, beat-counter width; must satisfy 2^CNT_W > NUM_BEATS.

Ports:
sys_clk  in  1  clock; all logic on rising edge.
sys_rst_n  in  1  asynchronous, active-low reset.
accu_en  in  1  enable; frame may start/continue only while high.
accu_finished  out  1  one-cycle pulse on the cycle the result beat is accepted.
s_axis_tvalid  in  1  input beat valid.
s_axis_tready  out  1  accumulator ready for input.
s_axis_tdata  in  DATA_W  signed input sample.
m_axis_tvalid  out  1  result valid.
m_axis_tready  in  1  downstream ready.
m_axis_tdata  out  DATA_W  signed accumulated result.

Behaviour:
- Reset (async, sys_rst_n=0): state=IDLE; acc=0; cnt=0; s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata=0; accu_finished=0. Outputs are registered.
- States: IDLE, ACCUM, OUTPUT.
- IDLE:
  - acc=0, cnt=0, s_axis_tready=0.
  - If accu_en=1, go to ACCUM next cycle; s_axis_tready rises that same edge.
- ACCUM:
  - s_axis_tready=1 while accu_en=1.
  - A beat transfers on any edge where s_axis_tvalid & s_axis_tready. Then acc <= acc + s_axis_tdata and cnt <= cnt + 1.
  - Cycles with tvalid=0 leave acc and cnt unchanged; gaps are arbitrary.
  - On the transfer where cnt == NUM_BEATS-1:
    - load m_axis_tdata with acc + s_axis_tdata;
    - set m_axis_tvalid=1 and s_axis_tready=0;
    - go to OUTPUT.
  - No input beat is accepted beyond NUM_BEATS.
- OUTPUT:
  - m_axis_tvalid=1, and m_axis_tdata is held stable until m_axis_tvalid & m_axis_tready.
  - On that handshake edge:
    - m_axis_tvalid<=0, accu_finished<=1 for exactly one cycle;
    - acc and cnt cleared; go to IDLE.
  - If accu_en is still 1, the next frame starts from IDLE on the following cycle. Minimum one idle cycle between frames.
  - m_axis_tready while m_axis_tvalid=0 is ignored.
- Arithmetic: full DATA_W two's-complement add. Without the optional feature, overflow wraps modulo 2^DATA_W.
- accu_en=0 during ACCUM: frame aborted. acc, cnt cleared; s_axis_tready<=0; go to IDLE; no result and no accu_finished.
- accu_en=0 during OUTPUT: ignored. The pending result is still delivered.
- Reset mid-frame: all state discarded immediately; partial sum is lost.
- s_axis_tready never depends combinationally on s_axis_tvalid. m_axis_tvalid never depends on m_axis_tready.

Optional Feature:
ACCU_SAT_EN
- Defined: each add saturates. Positive overflow clamps to 2^(DATA_W-1)-1; negative overflow clamps to -2^(DATA_W-1).
- Overflow is detected from the operand signs vs the result sign.
- Undefined: plain wrapping add, with no saturation logic synthesized.

Test Plan:
- Basic frame:
  - Stimulus: accu_en=1; send 11 beats 10,0,-10,…,-90 with one idle cycle between beats; m_axis_tready asserted one cycle after m_axis_tvalid.
  - Response: m_axis_tdata=-440 (0xFFFF_FFFF_FFFF_FE48); m_axis_tvalid stays high until the handshake; accu_finished pulses one cycle.
- Back-to-back input:
  - Stimulus: s_axis_tvalid held high for 11 beats of value 5.
  - Response: one beat per cycle accepted; result 55; s_axis_tready=0 from the cycle after the 11th beat until the next frame.
- Output backpressure:
  - Stimulus: m_axis_tready held low 8 cycles after a result.
  - Response: m_axis_tdata and m_axis_tvalid stable throughout; no extra s_axis_tready; accu_finished only on the handshake cycle.
- Enable gating:
  - Stimulus: accu_en=0 at reset release.
  - Response: s_axis_tready=0 and no beats accepted.
  - Stimulus: drop accu_en after 4 beats.
  - Response: abort, then with accu_en=1 a fresh 11-beat frame of 1s yields 11.
- Reset mid-frame: assert sys_rst_n=0 after 6 beats → all outputs return to reset values asynchronously; a subsequent full frame gives the correct sum.
- Overflow:
  - Stimulus: 11 beats of 0x7FFF_FFFF_FFFF_FFFF.
  - Response with ACCU_SAT_EN: 0x7FFF_FFFF_FFFF_FFFF.
  - Response without: wrapped value 0x7FFF_FFFF_FFFF_FFF5.
